// File: rtl/trigger_capture.sv
// Trigger capture: circular sample buffer with level-crossing trigger and
// programmable pre-trigger depth. Once the record is frozen it is read back
// relative to the record start.
module trigger_capture #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic              arm,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              capture_done,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRETRIG = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   lvl_q;
  logic                rising_q;
  logic [ADDR_W-1:0]   pretrig_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   prev_q;
  logic                prev_valid_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W-1:0]   trig_ptr_q;
  logic [ADDR_W-1:0]   post_cnt_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_en_c;
  logic                trig_hit_c;
  logic [ADDR_W-1:0]   cnt_next_c;
  logic [ADDR_W-1:0]   post_load_c;
  logic [ADDR_W-1:0]   start_ptr_c;
  logic [ADDR_W-1:0]   rd_idx_c;

  // Write/trigger qualifiers and record geometry
  always_comb begin
    wr_en_c     = sample_valid &&
                  (state_q == S_PRETRIG || state_q == S_ARMED || state_q == S_POST);
    trig_hit_c  = prev_valid_q &&
                  (rising_q ? (prev_q < lvl_q && sample_data >= lvl_q)
                            : (prev_q > lvl_q && sample_data <= lvl_q));
    cnt_next_c  = ADDR_W'(cnt_q + 1'b1);
    post_load_c = ADDR_W'(ADDR_W'(DEPTH - 1) - pretrig_q);
    start_ptr_c = ADDR_W'(trig_ptr_q - pretrig_q);
    rd_idx_c    = ADDR_W'(start_ptr_c + rd_addr);
  end

  // Sample storage, no reset (contents undefined until written)
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr_q] <= sample_data;
  end

  // Capture FSM, pointers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lvl_q        <= '0;
      rising_q     <= 1'b0;
      pretrig_q    <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      trig_ptr_q   <= '0;
      post_cnt_q   <= '0;
      rd_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      rd_data_q <= mem[rd_idx_c];

      if (wr_en_c) begin
        wr_ptr_q     <= ADDR_W'(wr_ptr_q + 1'b1);
        prev_q       <= sample_data;
        prev_valid_q <= 1'b1;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            lvl_q        <= trig_level;
            rising_q     <= trig_rising;
            pretrig_q    <= pretrig;
            cnt_q        <= '0;
            prev_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            state_q      <= (pretrig == '0) ? S_ARMED : S_PRETRIG;
          end
        end
        S_PRETRIG: begin
          if (sample_valid) begin
            cnt_q <= cnt_next_c;
            if (cnt_next_c == pretrig_q) state_q <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (sample_valid && trig_hit_c) begin
            trig_ptr_q <= wr_ptr_q;
            post_cnt_q <= post_load_c;
            if (post_load_c == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_POST;
            end
          end
        end
        S_POST: begin
          if (sample_valid) begin
            post_cnt_q <= ADDR_W'(post_cnt_q - 1'b1);
            if (post_cnt_q == ADDR_W'(1)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data      = rd_data_q;
  assign busy         = busy_q;
  assign capture_done = done_q;
  assign state        = state_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture (DATA_W=8, DEPTH=16).
module tb_trigger_capture;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk;
  logic              rst_n;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [DATA_W-1:0] trig_level;
  logic              trig_rising;
  logic [ADDR_W-1:0] pretrig;
  logic              arm;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              capture_done;
  logic [2:0]        state;

  int n_cmp;
  int n_err;

  trigger_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .trig_level(trig_level), .trig_rising(trig_rising), .pretrig(pretrig), .arm(arm),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .capture_done(capture_done),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    sample_valid = 1'b1;
    sample_data  = DATA_W'(v);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic do_arm(input int lvl, input bit rising, input int pt);
    trig_level  = DATA_W'(lvl);
    trig_rising = rising;
    pretrig     = ADDR_W'(pt);
    arm         = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int a, input int exp);
    rd_addr = ADDR_W'(a);
    tick();
    chk(tag, int'(rd_data), exp);
  endtask

  // Record of test 1: index i holds 60 + 10*i
  task automatic chk_ramp_record(input string tag);
    for (int i = 0; i < 16; i++) rd_chk(tag, i, 60 + 10 * i);
  endtask

  // State after ramp sample k with level 100 rising, pretrig 4
  function automatic int ramp_state(input int k);
    if (k <= 2) return 1;
    if (k <= 9) return 2;
    if (k <= 20) return 3;
    return 4;
  endfunction

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; sample_valid = 1'b0; sample_data = '0; trig_level = '0;
    trig_rising = 1'b0; pretrig = '0; arm = 1'b0; rd_addr = '0;

    // Reset state
    tick(); tick();
    chk("rst_state", int'(state), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(capture_done), 0);
    chk("rst_rd", int'(rd_data), 0);
    rst_n = 1'b1;
    tick();

    // Test 1: rising, level 100, pretrig 4, ramp 0,10,...
    do_arm(100, 1'b1, 4);
    chk("t1_arm_state", int'(state), 1);
    chk("t1_arm_busy", int'(busy), 1);
    for (int k = 0; k < 22; k++) begin
      send(10 * k);
      if (k == 3 || k == 10 || k == 20 || k == 21)
        chk($sformatf("t1_state_k%0d", k), int'(state), ramp_state(k));
    end
    chk("t1_done", int'(capture_done), 1);
    chk("t1_busy", int'(busy), 0);
    rd_chk("t1_rd0", 0, 60);
    rd_chk("t1_rd4", 4, 100);
    rd_chk("t1_rd15", 15, 210);

    // Test 2: falling, level 50, pretrig 2, descending ramp; arm from DONE
    do_arm(50, 1'b0, 2);
    chk("t2_done_drop", int'(capture_done), 0);
    chk("t2_arm_state", int'(state), 1);
    for (int k = 0; k < 18; k++) begin
      send(90 - 10 * k);
      if (k == 1) chk("t2_armed", int'(state), 2);
      if (k == 3) chk("t2_no_trig", int'(state), 2);
      if (k == 4) chk("t2_trig", int'(state), 3);
      if (k == 16) chk("t2_post", int'(state), 3);
    end
    chk("t2_state_done", int'(state), 4);
    rd_chk("t2_rd2", 2, 50);
    rd_chk("t2_rd0", 0, 70);
    rd_chk("t2_rd15", 15, 176);

    // Test 3: pretrig 0 skips PRETRIG
    do_arm(5, 1'b1, 0);
    chk("t3_arm_state", int'(state), 2);
    send(0);
    chk("t3_first", int'(state), 2);
    send(10);
    chk("t3_trig", int'(state), 3);
    for (int k = 2; k < 17; k++) send(10 * k);
    chk("t3_done", int'(state), 4);
    rd_chk("t3_rd0", 0, 10);
    rd_chk("t3_rd15", 15, 160);

    // Test 3b: first sample equal to level, then flat, never triggers until a crossing
    do_arm(5, 1'b1, 0);
    send(5);
    chk("t3b_first_eq", int'(state), 2);
    send(5);
    chk("t3b_flat", int'(state), 2);
    send(0);
    chk("t3b_below", int'(state), 2);
    send(10);
    chk("t3b_trig", int'(state), 3);
    for (int k = 0; k < 15; k++) send(20 + k);
    chk("t3b_done", int'(state), 4);
    rd_chk("t3b_rd0", 0, 10);
    rd_chk("t3b_rd1", 1, 20);

    // Test 4/5: test 1 with valid every third cycle, arm pulsed while ARMED
    do_arm(100, 1'b1, 4);
    for (int k = 0; k < 22; k++) begin
      if (k == 6) begin
        trig_level = 8'd0; trig_rising = 1'b0; pretrig = 4'd0; arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t5_arm_ignored", int'(state), 2);
      end else begin
        tick();
        chk($sformatf("t4_gap_a_k%0d", k), int'(state), (k == 0) ? 1 : ramp_state(k - 1));
      end
      tick();
      chk($sformatf("t4_gap_b_k%0d", k), int'(state), (k == 0) ? 1 : ramp_state(k - 1));
      send(10 * k);
      chk($sformatf("t4_state_k%0d", k), int'(state), ramp_state(k));
    end
    chk("t4_done", int'(capture_done), 1);
    chk_ramp_record("t4_rec");

    // Test 6: asynchronous reset during POST, then a full capture
    do_arm(100, 1'b1, 4);
    for (int k = 0; k < 13; k++) send(10 * k);
    chk("t6_in_post", int'(state), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_state", int'(state), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_done", int'(capture_done), 0);
    chk("t6_rst_rd", int'(rd_data), 0);
    rst_n = 1'b1;
    tick();
    chk("t6_idle", int'(state), 0);
    do_arm(100, 1'b1, 4);
    for (int k = 0; k < 22; k++) send(10 * k);
    chk("t6_done", int'(capture_done), 1);
    chk_ramp_record("t6_rec");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
